// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, assembles a 32-bit little-endian
// instruction from four byte reads on the shared byte-wide memory port,
// holds the pipeline via stallreq_o until the word is complete, and
// applies branch redirects from ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_busy_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_re_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [2:0]  if_cnt_o,
  output logic        stallreq_o
);

  localparam logic [2:0] BYTES = 3'd4;

  logic [31:0] pc_q, pc_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        rd_pending_q, rd_pending_d;

  logic        word_done;
  logic        issue;

  assign word_done = (recv_cnt_q == BYTES);

  // A read goes out whenever bytes remain to be requested and neither MEM
  // owns the port nor a redirect is discarding this fetch.
  assign issue      = (issue_cnt_q < BYTES) && !mem_busy_i && !branch_flag_i;
  assign mem_re_o   = issue;
  assign mem_addr_o = issue ? (pc_q + {29'd0, issue_cnt_q}) : pc_q;

  assign stallreq_o = !word_done;
  assign if_inst    = word_done ? inst_buf_q : 32'd0;
  assign if_pc      = pc_q;
  assign if_cnt_o   = recv_cnt_q;

  // Next-state: redirect beats advance beats normal issue/capture progress.
  always_comb begin
    pc_d         = pc_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    inst_buf_d   = inst_buf_q;
    rd_pending_d = 1'b0;
    if (branch_flag_i) begin
      // In-flight byte is dropped by clearing rd_pending with the counters.
      pc_d        = branch_target_i;
      issue_cnt_d = 3'd0;
      recv_cnt_d  = 3'd0;
      inst_buf_d  = 32'd0;
    end else if (word_done && !stall[0]) begin
      pc_d        = pc_q + 32'd4;
      issue_cnt_d = 3'd0;
      recv_cnt_d  = 3'd0;
      inst_buf_d  = 32'd0;
    end else begin
      if (issue) begin
        issue_cnt_d  = issue_cnt_q + 3'd1;
        rd_pending_d = 1'b1;
      end
      // Capture ignores mem_busy_i and stall: the data is already on the bus.
      if (rd_pending_q && !word_done) begin
        inst_buf_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_data_i;
        recv_cnt_d = recv_cnt_q + 3'd1;
      end
    end
  end

  // State registers with synchronous reset; partial bytes are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      issue_cnt_q  <= 3'd0;
      recv_cnt_q   <= 3'd0;
      inst_buf_q   <= 32'd0;
      rd_pending_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      inst_buf_q   <= inst_buf_d;
      rd_pending_q <= rd_pending_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a small byte memory answering one cycle
// after each read strobe.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_busy_i;
  logic [7:0]  mem_data_i;
  logic [31:0] mem_addr_o;
  logic        mem_re_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [2:0]  if_cnt_o;
  logic        stallreq_o;

  int vectors = 0;
  int errs    = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .mem_busy_i(mem_busy_i), .mem_data_i(mem_data_i),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o),
    .if_pc(if_pc), .if_inst(if_inst), .if_cnt_o(if_cnt_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;  32'h1: return 8'h00;
      32'h2: return 8'h00;  32'h3: return 8'h00;
      32'h4: return 8'h93;  32'h5: return 8'h80;
      32'h6: return 8'h10;  32'h7: return 8'h00;
      32'h100: return 8'h37; 32'h101: return 8'h12;
      32'h102: return 8'h00; 32'h103: return 8'h00;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Memory: data for a strobed read appears the following cycle; otherwise
  // junk, so any stray capture is visible in if_inst.
  always @(posedge clk) begin
    if (mem_re_o) mem_data_i <= mem_byte(mem_addr_o);
    else          mem_data_i <= 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [2:0] cnt,
                           input logic [31:0] inst, input logic sreq);
    chk({tag, ".pc"},   if_pc, pc);
    chk({tag, ".cnt"},  {29'd0, if_cnt_o}, {29'd0, cnt});
    chk({tag, ".inst"}, if_inst, inst);
    chk({tag, ".sreq"}, {31'd0, stallreq_o}, {31'd0, sreq});
  endtask

  task automatic chk_rd(input string tag, input logic re, input logic [31:0] addr);
    chk({tag, ".re"}, {31'd0, mem_re_o}, {31'd0, re});
    if (re) chk({tag, ".addr"}, mem_addr_o, addr);
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; branch_flag_i = 1'b0;
    branch_target_i = 32'd0; mem_busy_i = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    // c0: reset state, first read at RESET_PC
    chk_state("rst", 32'h0, 3'd0, 32'h0, 1'b1);
    chk_rd("rst", 1'b1, 32'h0);

    // Basic fetch at 0: reads 0..3 back to back
    step(); chk_rd("f0.c1", 1'b1, 32'h1); chk_state("f0.c1", 32'h0, 3'd0, 32'h0, 1'b1);
    step(); chk_rd("f0.c2", 1'b1, 32'h2); chk_state("f0.c2", 32'h0, 3'd1, 32'h0, 1'b1);
    step(); chk_rd("f0.c3", 1'b1, 32'h3); chk_state("f0.c3", 32'h0, 3'd2, 32'h0, 1'b1);
    step(); chk_rd("f0.c4", 1'b0, 32'h0); chk_state("f0.c4", 32'h0, 3'd3, 32'h0, 1'b1);
    step(); chk_rd("f0.c5", 1'b0, 32'h0); chk_state("f0.c5", 32'h0, 3'd4, 32'h0000_0013, 1'b0);
    step(); chk_rd("f0.adv", 1'b1, 32'h4); chk_state("f0.adv", 32'h4, 3'd0, 32'h0, 1'b1);

    // Fetch at 4 with two busy cycles after byte1 issue
    step(); chk_rd("bz.b1", 1'b1, 32'h5);
    step(); mem_busy_i = 1'b1; #1;
    chk_rd("bz.busy1", 1'b0, 32'h0); chk_state("bz.busy1", 32'h4, 3'd1, 32'h0, 1'b1);
    step(); chk_rd("bz.busy2", 1'b0, 32'h0); chk_state("bz.busy2", 32'h4, 3'd2, 32'h0, 1'b1);
    step(); mem_busy_i = 1'b0; #1;
    chk_rd("bz.b2", 1'b1, 32'h6);
    step(); chk_rd("bz.b3", 1'b1, 32'h7);
    step(); chk_state("bz.c3", 32'h4, 3'd3, 32'h0, 1'b1);
    step(); chk_state("bz.done", 32'h4, 3'd4, 32'h0010_8093, 1'b0);

    // Completed word held by downstream stall for three edges
    stall = 6'b000111; #1;
    chk_rd("hold0", 1'b0, 32'h0);
    step(); chk_state("hold1", 32'h4, 3'd4, 32'h0010_8093, 1'b0); chk_rd("hold1", 1'b0, 32'h0);
    step(); chk_state("hold2", 32'h4, 3'd4, 32'h0010_8093, 1'b0); chk_rd("hold2", 1'b0, 32'h0);
    step(); chk_state("hold3", 32'h4, 3'd4, 32'h0010_8093, 1'b0); chk_rd("hold3", 1'b0, 32'h0);
    stall = 6'd0;
    step(); chk_state("hold.adv", 32'h8, 3'd0, 32'h0, 1'b1); chk_rd("hold.adv", 1'b1, 32'h8);

    // Branch while recv_cnt=2 with a read pending
    step(); step(); step();
    chk_state("br.pre", 32'h8, 3'd2, 32'h0, 1'b1); chk_rd("br.pre", 1'b1, 32'hB);
    branch_flag_i = 1'b1; branch_target_i = 32'h0000_0100; #1;
    chk_rd("br.cyc", 1'b0, 32'h0);
    step(); branch_flag_i = 1'b0; #1;
    chk_state("br.new", 32'h100, 3'd0, 32'h0, 1'b1); chk_rd("br.new", 1'b1, 32'h100);
    step(); chk_state("br.nocap", 32'h100, 3'd0, 32'h0, 1'b1); chk_rd("br.nocap", 1'b1, 32'h101);
    step(); step(); step(); step();
    chk_state("br.done", 32'h100, 3'd4, 32'h0000_1237, 1'b0);

    // Branch coinciding with completion, stall[0]=0: branch wins
    branch_flag_i = 1'b1; branch_target_i = 32'h0000_0200; #1;
    chk_rd("brc.cyc", 1'b0, 32'h0);
    step(); branch_flag_i = 1'b0; #1;
    chk_state("brc.new", 32'h200, 3'd0, 32'h0, 1'b1); chk_rd("brc.new", 1'b1, 32'h200);

    // Reset at recv_cnt=3
    step(); step(); step(); step();
    chk_state("rs.pre", 32'h200, 3'd3, 32'h0, 1'b1);
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk_state("rs.post", 32'h0, 3'd0, 32'h0, 1'b1); chk_rd("rs.post", 1'b1, 32'h0);
    step(); step(); step(); step(); step();
    chk_state("rs.done", 32'h0, 3'd4, 32'h0000_0013, 1'b0);

    // Address wrap across 2^32
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
    step(); branch_flag_i = 1'b0; #1;
    chk_rd("wr.b0", 1'b1, 32'hFFFF_FFFE);
    step(); chk_rd("wr.b1", 1'b1, 32'hFFFF_FFFF);
    step(); chk_rd("wr.b2", 1'b1, 32'h0000_0000);
    step(); chk_rd("wr.b3", 1'b1, 32'h0000_0001);
    step(); step();
    chk_state("wr.done", 32'hFFFF_FFFE, 3'd4, 32'h0013_5A5B, 1'b0);
    step(); chk_state("wr.adv", 32'h0000_0002, 3'd0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
